key_press_detector: RTL and testbench

- Input-side counterpart to the board's counter-driven LED outputs.
- Samples one raw push-button, synchronises it and debounces it.
- Emits single-cycle event pulses: press, release, short-press and long-press.
- Also provides a clean debounced level, so top-level logic (LED mode select, etc.) reacts to user input instead of free-running counters.

---
 rtl/key_press_detector_pkg.sv | 14 +
 rtl/key_press_detector_sync_2ff.sv | 23 ++
 rtl/key_press_detector.sv | 130 +++++++++++++
 tb/tb_key_press_detector.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_press_detector_pkg.sv
// Shared definitions for the push-button front end: FSM state codes and ms-to-cycles conversion.
package key_press_detector_pkg;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] DB_PRESS   = 2'd1;
    localparam logic [1:0] HELD       = 2'd2;
    localparam logic [1:0] DB_RELEASE = 2'd3;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                                 input int unsigned ms);
        return clk_freq / 1000 * ms;
    endfunction

endpackage

// File: rtl/key_press_detector_sync_2ff.sv
// Two-flop synchroniser for asynchronous switch/button pins; both flops reset to RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_press_detector.sv
// Debounced push-button: clean level plus press, release, short-press and long-press pulses.
module key_press_detector
    import key_press_detector_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_value,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse
);

    localparam int unsigned DB_CYC   = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYC = ms_to_cycles(CLK_FREQ, LONG_MS);
    localparam int unsigned DB_W     = $clog2(DB_CYC) + 1;
    localparam int unsigned LONG_W   = $clog2(LONG_CYC) + 1;
    localparam bit          DB_ONE   = (DB_CYC == 1);

    // The edge that enters a debounce state already counts as the first stable cycle,
    // so acceptance happens when the count about to be written reaches DB_CYC-1.
    localparam logic [DB_W-1:0]   DB_LAST   = (DB_CYC >= 2) ? DB_W'(DB_CYC - 2) : '0;
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);

    if (DB_CYC < 1 || LONG_CYC <= DB_CYC) begin : g_param_check
        $error("key_press_detector: need DB_CYC >= 1 and LONG_CYC > DB_CYC");
    end

    logic              key_sync;
    logic              key_act;
    logic [1:0]        state;
    logic [DB_W-1:0]   db_cnt;
    logic [LONG_W-1:0] hold_cnt;
    logic [LONG_W-1:0] hold_next;
    logic              long_done;
    logic              long_hit;

    sync_2ff #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .d         (key_in),
        .q         (key_sync)
    );

    assign key_act = key_sync ^ ACTIVE_LOW;

    always_comb begin
        hold_next = (hold_cnt == LONG_LAST) ? hold_cnt : hold_cnt + 1'b1;
        long_hit  = (hold_next == LONG_LAST) && !long_done;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            key_value     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_act) begin
                        db_cnt <= '0;
                        if (DB_ONE) begin
                            state       <= HELD;
                            key_value   <= 1'b1;
                            press_pulse <= 1'b1;
                            hold_cnt    <= '0;
                            long_done   <= 1'b0;
                        end else begin
                            state <= DB_PRESS;
                        end
                    end
                end
                DB_PRESS: begin
                    if (!key_act) begin
                        state <= IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= HELD;
                        key_value   <= 1'b1;
                        press_pulse <= 1'b1;
                        hold_cnt    <= '0;
                        long_done   <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HELD, DB_RELEASE: begin
                    hold_cnt <= hold_next;
                    if (long_hit) begin
                        long_pulse <= 1'b1;
                        long_done  <= 1'b1;
                    end
                    // A bounce back to pressed during release debounce simply resumes HELD.
                    if (key_act) begin
                        state <= HELD;
                    end else if (DB_ONE || (state == DB_RELEASE && db_cnt == DB_LAST)) begin
                        state         <= IDLE;
                        key_value     <= 1'b0;
                        release_pulse <= 1'b1;
                        short_pulse   <= !(long_done || long_hit);
                    end else if (state == HELD) begin
                        state  <= DB_RELEASE;
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_press_detector.sv
// Bench for key_press_detector: press table, directed corner cases and random stimulus vs a run-length model.
module tb_key_press_detector;

    localparam int DB_CYC   = 5;
    localparam int LONG_CYC = 20;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;
    logic key_in    = 1'b1;
    logic key_value, press_pulse, release_pulse, short_pulse, long_pulse;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    key_press_detector #(
        .CLK_FREQ    (1000),
        .DEBOUNCE_MS (5),
        .LONG_MS     (20),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .key_in        (key_in),
        .key_value     (key_value),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference: count consecutive sampled cycles disagreeing with the accepted level;
    // DB_CYC of them flips the level. Hold time is counted in edges since acceptance.
    logic s1 = 1'b1, s2 = 1'b1;
    bit   pressed, m_press, m_rel, m_short, m_long, ldone;
    int   run, hold;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1 = 1'b1; s2 = 1'b1;
            pressed = 0; m_press = 0; m_rel = 0; m_short = 0; m_long = 0;
            ldone = 0; run = 0; hold = 0;
        end else begin
            bit ka;
            ka = !s2;
            s2 = s1;
            s1 = key_in;
            m_press = 0; m_rel = 0; m_short = 0; m_long = 0;
            if (pressed) begin
                hold++;
                if (hold == LONG_CYC - 1 && !ldone) begin
                    m_long = 1;
                    ldone  = 1;
                end
            end
            if (ka != pressed) run++;
            else run = 0;
            if (run == DB_CYC) begin
                run = 0;
                if (!pressed) begin
                    pressed = 1; m_press = 1; hold = 0; ldone = 0;
                end else begin
                    pressed = 0; m_rel = 1; m_short = !ldone;
                end
            end
        end
    end

    int n_press, n_rel, n_short, n_long;
    int f_press, f_rel, f_short, f_long;

    always @(negedge sys_clk) begin
        logic [4:0] act, exp;
        act = {key_value, press_pulse, release_pulse, short_pulse, long_pulse};
        exp = {pressed, m_press, m_rel, m_short, m_long};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL model cyc=%0d actual kv/pr/rl/sh/lg=%b required=%b", cyc, act, exp);
        end
        checks++;
        if (press_pulse && release_pulse) begin
            failures++;
            $display("FAIL exclusive cyc=%0d actual press&release=1 required=0", cyc);
        end
        if (press_pulse)   begin if (n_press == 0) f_press = cyc; n_press++; end
        if (release_pulse) begin if (n_rel   == 0) f_rel   = cyc; n_rel++;   end
        if (short_pulse)   begin if (n_short == 0) f_short = cyc; n_short++; end
        if (long_pulse)    begin if (n_long  == 0) f_long  = cyc; n_long++;  end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        n_press = 0; n_rel = 0; n_short = 0; n_long = 0;
        f_press = -1; f_rel = -1; f_short = -1; f_long = -1;
        cyc = 0;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        int start;
        int len;
        int exp_press;
        int exp_long;
        int exp_rel;
        int exp_short;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{10, 10, 17, -1, 27, 27};   // clean short press
        vecs[1] = '{10, 50, 17, 36, 67, -1};   // long press
        vecs[2] = '{10, 19, 17, 36, 36, -1};   // long and release on the same edge
        vecs[3] = '{10, 18, 17, -1, 35, 35};   // release one cycle before long
        vecs[4] = '{10,  5, 17, -1, 22, 22};   // minimum accepted press
        vecs[5] = '{10,  4, -1, -1, -1, -1};   // glitch one cycle too short

        clear_log();
        #1 sys_rst_n = 1'b0;
        idle(3);
        check("reset_outputs", {key_value, press_pulse, release_pulse, short_pulse, long_pulse}, 0);
        sys_rst_n = 1'b1;

        clear_log();
        idle(50);
        check("idle_pulses", n_press + n_rel + n_short + n_long, 0);
        check("idle_level", key_value, 0);

        foreach (vecs[v]) begin
            clear_log();
            for (int t = 0; t < 90; t++) begin
                tick();
                if (cyc == vecs[v].start) key_in = 1'b0;
                if (cyc == vecs[v].start + vecs[v].len) key_in = 1'b1;
            end
            check($sformatf("v%0d_press_cyc", v), f_press, vecs[v].exp_press);
            check($sformatf("v%0d_press_n", v), n_press, vecs[v].exp_press >= 0);
            check($sformatf("v%0d_long_cyc", v), f_long, vecs[v].exp_long);
            check($sformatf("v%0d_long_n", v), n_long, vecs[v].exp_long >= 0);
            check($sformatf("v%0d_rel_cyc", v), f_rel, vecs[v].exp_rel);
            check($sformatf("v%0d_rel_n", v), n_rel, vecs[v].exp_rel >= 0);
            check($sformatf("v%0d_short_cyc", v), f_short, vecs[v].exp_short);
            check($sformatf("v%0d_short_n", v), n_short, vecs[v].exp_short >= 0);
        end

        // Bounce on press: toggles every 2 cycles, final falling edge at cycle 22.
        clear_log();
        for (int t = 0; t < 60; t++) begin
            tick();
            if (cyc >= 10 && cyc < 22 && (cyc % 2 == 0)) key_in = ~key_in;
            if (cyc == 22) key_in = 1'b0;
            if (cyc == 28) check("bounce_quiet", n_press + n_rel + n_short + n_long, 0);
        end
        check("bounce_press_cyc", f_press, 29);
        check("bounce_press_n", n_press, 1);
        key_in = 1'b1;
        idle(20);

        // Bounce on release: 3 cycles high mid-hold must not end the press.
        clear_log();
        for (int t = 0; t < 90; t++) begin
            tick();
            if (cyc == 10) key_in = 1'b0;
            if (cyc == 25) key_in = 1'b1;
            if (cyc == 28) key_in = 1'b0;
            if (cyc == 60) key_in = 1'b1;
            if (cyc == 50) check("rbounce_level", key_value, 1);
        end
        check("rbounce_press_cyc", f_press, 17);
        check("rbounce_long_cyc", f_long, 36);
        check("rbounce_rel_cyc", f_rel, 67);
        check("rbounce_rel_n", n_rel, 1);
        check("rbounce_short_n", n_short, 0);

        // Reset 5 cycles after the press, button still held.
        clear_log();
        for (int t = 0; t < 22; t++) begin
            tick();
            if (cyc == 10) key_in = 1'b0;
        end
        check("rmid_press_cyc", f_press, 17);
        sys_rst_n = 1'b0;
        #1;
        check("rmid_cleared", {key_value, press_pulse, release_pulse, short_pulse, long_pulse}, 0);
        idle(3);
        sys_rst_n = 1'b1;
        clear_log();
        for (int t = 0; t < 12; t++) tick();
        check("rmid_no_release", n_rel + n_short, 0);
        check("rmid_repress_cyc", f_press, 7);
        check("rmid_repress_n", n_press, 1);
        key_in = 1'b1;
        idle(20);

        // Random segments against the model, with occasional reset.
        for (int s = 0; s < 250; s++) begin
            key_in = ~key_in;
            idle($urandom_range(1, 30));
            if ($urandom_range(0, 39) == 0) begin
                sys_rst_n = 1'b0;
                idle(2);
                sys_rst_n = 1'b1;
            end
        end
        key_in = 1'b1;
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
